register_fifo_multi: RTL and testbench
======================================

# register_fifo_multi

Parametrised register-based FIFO and the multi-entry successor to our single-entry fast register FIFO. It holds WIDTH-bit words in a flop array of DEPTH entries. It presents the head word show-ahead on `q`. Like the single-entry block, `full` is combinationally relieved by a same-cycle read, so a full FIFO can accept a write in the cycle it is read. It is used on short-latency streaming paths between pipeline stages where RAM-based FIFOs are too slow or too large, and it adds occupancy reporting and an almost-full watermark.

## Interface
- WIDTH, 32, data word width in bits (≥1)
- DEPTH, 4, number of entries (≥2; any integer, not restricted to powers of two)
- AF_THRESH, DEPTH-1, almost_full asserts when occupancy ≥ AF_THRESH (1..DEPTH)
- clock  input  1  clock; all state updates on posedge
- reset_n  input  1  reset, synchronous, active-low
- wrreq  input  1  write request; accepted when `~full`
- data  input  WIDTH  write data
- full  output  1  `(count==DEPTH) & ~rdreq`
- almost_full  output  1  registered, `count >= AF_THRESH`
- rdreq  input  1  read request; pops head when `~empty`
- empty  output  1  registered, `count==0`
- q  output  WIDTH  head entry, valid whenever `~empty`
- usedw  output  $clog2(DEPTH+1)  current occupancy (count), registered
- overflow  output  1  sticky error flag; see Configuration
- underflow  output  1  sticky error flag; see Configuration

## Operation
- State:
  - storage array `mem[DEPTH]`, not reset
  - read pointer `rd_ptr` and write pointer `wr_ptr`, range 0..DEPTH-1, wrap DEPTH-1 → 0
  - `count`, range 0..DEPTH
- Effective operations per cycle:
  - `do_wr = wrreq & ~full`
  - `do_rd = rdreq & ~empty`
- On a posedge:
  - do_wr: write `mem[wr_ptr] <= data` and advance `wr_ptr`.
  - do_rd: advance `rd_ptr`.
  - count update: `+1` if do_wr only; `-1` if do_rd only; unchanged if both or neither.
- `q = mem[rd_ptr]` (combinational mux from registered state; no rdreq in the path).
- Boundary rules:
  - Full with wrreq & rdreq: both occur. `full` is low that cycle and count stays DEPTH.
  - Full with wrreq only: write dropped. Storage, pointers and count are unchanged.
  - Empty with wrreq & rdreq: the write is taken and the read is ignored (no fall-through). count becomes 1.
  - Empty with rdreq only: ignored.
  - Pointer wrap is an explicit compare to DEPTH-1, not a modulo.
- Reset (any cycle, including mid-stream):
  - Pointers, count and usedw go to 0.
  - `empty`=1, `almost_full`=0, `full`=0, `overflow`=`underflow`=0.
  - `q` is unspecified (X permitted) until the first write. Contents are discarded.

## Timing
- Write-to-read latency is 1 cycle: a word written at edge N is visible on `q` with `empty`=0 after edge N.
- Read: `q` updates to the next entry after the edge that pops.
- `full` depends on `rdreq` combinationally, as in the single-entry block. Upstream logic must not feed `full` back into `rdreq`.
- `empty`, `almost_full` and `usedw` are registered, computed from the next count, with no combinational input paths.
- Sustained throughput is one write and one read per cycle at any occupancy, including full. The only exception is empty, where a read is not possible.

## Configuration
- Macro: `REGISTER_FIFO_MULTI_ERR_CHECK_EN`.
- Defined:
  - `overflow` sets on `wrreq & full`.
  - `underflow` sets on `rdreq & empty`.
  - Both are sticky until reset.
  - Simulation `$error` is issued on each event.
- Undefined: `overflow` and `underflow` are tied 0 and no error logic is built. The port list is identical in both builds.

## Structure
- `register_fifo_pkg`:
  - `clog2`-based width helper functions for pointers and usedw
  - localparam rules for parameter legality (DEPTH ≥ 2, 1 ≤ AF_THRESH ≤ DEPTH), checked at elaboration
- Sub-module `register_fifo_ptr`: a wrapping pointer register with increment enable. It is instantiated twice (rd and wr).

## Test plan
- Reset, then idle: `empty`=1, `full`=0, `usedw`=0, `almost_full`=0 for 10 cycles.
- DEPTH=4: write 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - After the 4th edge: `usedw`=4 and `almost_full`=1 (set from usedw=3), and `full`=1 while rdreq=0.
  - Read four times: q sequence 0x11, 0x22, 0x33, 0x44, then `empty`=1.
- Full FIFO, assert wrreq & rdreq with data 0x55: `full`=0 that cycle, `usedw` stays 4, and head advances to 0x22. 0x55 is read last.
- Full FIFO, wrreq only with 0x66: word dropped, `usedw`=4. With the macro defined, `overflow`=1 and stays 1.
- Empty FIFO, wrreq & rdreq with 0x77 in the same cycle: `usedw`=1 and `q`=0x77 next cycle. `rdreq` on empty with the macro defined sets `underflow`.
- Stream 1000 random words with random wrreq/rdreq at DEPTH=3 (non-power-of-two wrap), with a reset asserted mid-stream: data order is checked against a scoreboard, which is flushed at reset. Post-reset outputs match the reset values.

Source files
------------

// File: rtl/register_fifo_pkg.sv
// Shared helpers for the register-based FIFO family: pointer and occupancy
// width functions plus the parameter legality rules the top enforces at
// elaboration.
package register_fifo_pkg;

  localparam int MIN_DEPTH     = 2;
  localparam int MIN_AF_THRESH = 1;

  // Pointer width for a ring of 'depth' entries (never narrower than 1 bit).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width: must hold every value from 0 up to depth.
  function automatic int usedw_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // DEPTH must be at least two entries and the watermark must lie in 1..DEPTH.
  function automatic bit params_legal(input int depth, input int af_thresh);
    return (depth >= MIN_DEPTH) && (af_thresh >= MIN_AF_THRESH) && (af_thresh <= depth);
  endfunction

endpackage

// File: rtl/register_fifo_ptr.sv
// Wrapping pointer register with increment enable. Wrap is an explicit
// compare against DEPTH-1, so any non-power-of-two depth works.
module register_fifo_ptr
  import register_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  // Advance by one on inc, wrapping from the last slot back to slot zero.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/register_fifo_multi.sv
// Multi-entry register FIFO with show-ahead head on q. 'full' is relieved
// combinationally by a same-cycle read so a full FIFO keeps streaming at one
// word per cycle. empty, almost_full and usedw are registered from the next
// occupancy.
// Optional build macro: REGISTER_FIFO_MULTI_ERR_CHECK_EN enables the sticky
// overflow/underflow flags; without it both outputs are tied low.
module register_fifo_multi
  import register_fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          wrreq,
  input  logic [WIDTH-1:0]              data,
  output logic                          full,
  output logic                          almost_full,
  input  logic                          rdreq,
  output logic                          empty,
  output logic [WIDTH-1:0]              q,
  output logic [usedw_width(DEPTH)-1:0] usedw,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int PTR_W   = ptr_width(DEPTH);
  localparam int USEDW_W = usedw_width(DEPTH);
  localparam logic [USEDW_W-1:0] COUNT_FULL = USEDW_W'(DEPTH);
  localparam logic [USEDW_W-1:0] COUNT_AF   = USEDW_W'(AF_THRESH);

  // Reject illegal depth/watermark combinations before anything is built.
  if (!params_legal(DEPTH, AF_THRESH)) begin : g_illegal_params
    $error("register_fifo_multi: illegal DEPTH=%0d / AF_THRESH=%0d", DEPTH, AF_THRESH);
  end

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [USEDW_W-1:0] count;
  logic [USEDW_W-1:0] next_count;
  logic               do_wr;
  logic               do_rd;

  // Full is held off by a same-cycle read; effective ops gate the raw requests.
  assign full  = (count == COUNT_FULL) & ~rdreq;
  assign do_wr = wrreq & ~full;
  assign do_rd = rdreq & ~empty;
  assign q     = mem[rd_ptr];
  assign usedw = count;

  register_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (do_wr),
    .ptr     (wr_ptr)
  );

  register_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (do_rd),
    .ptr     (rd_ptr)
  );

  // Storage is not reset; only accepted writes land in the array.
  always_ff @(posedge clock) begin
    if (do_wr) begin
      mem[wr_ptr] <= data;
    end
  end

  // Next occupancy: a simultaneous read and write leave the count unchanged.
  always_comb begin
    next_count = count;
    unique case ({do_wr, do_rd})
      2'b10:   next_count = count + 1'b1;
      2'b01:   next_count = count - 1'b1;
      default: next_count = count;
    endcase
  end

  // Occupancy and the flags derived from it are all registered from next_count.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count       <= '0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
    end else begin
      count       <= next_count;
      empty       <= (next_count == '0);
      almost_full <= (next_count >= COUNT_AF);
    end
  end

`ifdef REGISTER_FIFO_MULTI_ERR_CHECK_EN
  // Sticky error flags: set on a dropped write or a read of an empty FIFO.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wrreq && full) begin
        overflow <= 1'b1;
      end
      if (rdreq && empty) begin
        underflow <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  // Flag each error event loudly in simulation.
  always_ff @(posedge clock) begin
    if (reset_n && wrreq && full) begin
      $error("register_fifo_multi: write to full FIFO dropped");
    end
    if (reset_n && rdreq && empty) begin
      $error("register_fifo_multi: read from empty FIFO ignored");
    end
  end
`endif
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_register_fifo_multi.sv
// Directed bench for register_fifo_multi: a DEPTH=4 instance for the boundary
// cases and a DEPTH=3 instance for a random stream against a queue model.
module tb_register_fifo_multi;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // DEPTH=4, WIDTH=32 instance
  logic        reset4_n;
  logic        wrreq4;
  logic        rdreq4;
  logic [31:0] data4;
  logic        full4;
  logic        af4;
  logic        empty4;
  logic [31:0] q4;
  logic [2:0]  usedw4;
  logic        ovf4;
  logic        unf4;

  // DEPTH=3, WIDTH=8 instance
  logic        reset3_n;
  logic        wrreq3;
  logic        rdreq3;
  logic [7:0]  data3;
  logic        full3;
  logic        af3;
  logic        empty3;
  logic [7:0]  q3;
  logic [1:0]  usedw3;
  logic        ovf3;
  logic        unf3;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb [$];

  register_fifo_multi #(.WIDTH(32), .DEPTH(4)) dut4 (
    .clock       (clock),
    .reset_n     (reset4_n),
    .wrreq       (wrreq4),
    .data        (data4),
    .full        (full4),
    .almost_full (af4),
    .rdreq       (rdreq4),
    .empty       (empty4),
    .q           (q4),
    .usedw       (usedw4),
    .overflow    (ovf4),
    .underflow   (unf4)
  );

  register_fifo_multi #(.WIDTH(8), .DEPTH(3)) dut3 (
    .clock       (clock),
    .reset_n     (reset3_n),
    .wrreq       (wrreq3),
    .data        (data3),
    .full        (full3),
    .almost_full (af3),
    .rdreq       (rdreq3),
    .empty       (empty3),
    .q           (q3),
    .usedw       (usedw3),
    .overflow    (ovf3),
    .underflow   (unf3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] d);
    wrreq4 = wr;
    rdreq4 = rd;
    data4  = d;
  endtask

  task automatic writeWord(input logic [31:0] d);
    applyStimulus(1'b1, 1'b0, d);
    tick();
  endtask

  task automatic readExpect(input string tag, input logic [31:0] expected);
    applyStimulus(1'b0, 1'b1, 32'h0);
    #1;
    checkOutput(tag, q4, expected);
    tick();
  endtask

  task automatic checkReset4(input string tag);
    checkOutput({tag, "_empty"}, {31'b0, empty4}, 32'd1);
    checkOutput({tag, "_full"},  {31'b0, full4},  32'd0);
    checkOutput({tag, "_usedw"}, {29'b0, usedw4}, 32'd0);
    checkOutput({tag, "_af"},    {31'b0, af4},    32'd0);
    checkOutput({tag, "_ovf"},   {31'b0, ovf4},   32'd0);
    checkOutput({tag, "_unf"},   {31'b0, unf4},   32'd0);
  endtask

  task automatic checkReset3(input string tag);
    checkOutput({tag, "_empty"}, {31'b0, empty3}, 32'd1);
    checkOutput({tag, "_full"},  {31'b0, full3},  32'd0);
    checkOutput({tag, "_usedw"}, {30'b0, usedw3}, 32'd0);
    checkOutput({tag, "_af"},    {31'b0, af3},    32'd0);
    checkOutput({tag, "_ovf"},   {31'b0, ovf3},   32'd0);
    checkOutput({tag, "_unf"},   {31'b0, unf3},   32'd0);
  endtask

  initial begin
    logic [31:0] words [4];
    logic        wr;
    logic        rd;
    logic        exp_full;
    int          sz;

    reset4_n = 1'b0;
    reset3_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    wrreq3 = 1'b0;
    rdreq3 = 1'b0;
    data3  = 8'h0;
    repeat (3) tick();
    reset4_n = 1'b1;
    reset3_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      checkReset4("idle");
    end

    // Fill to DEPTH=4; almost_full rises at occupancy 3
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
    for (int i = 0; i < 4; i++) begin
      writeWord(words[i]);
      checkOutput("fill_usedw", {29'b0, usedw4}, 32'(i + 1));
      checkOutput("fill_af",    {31'b0, af4},    (i >= 2) ? 32'd1 : 32'd0);
      checkOutput("fill_empty", {31'b0, empty4}, 32'd0);
      checkOutput("fill_q",     q4,              32'h11);
    end
    applyStimulus(1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("full_no_rd", {31'b0, full4}, 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h0);
    #1;
    checkOutput("full_rd_relief", {31'b0, full4}, 32'd0);

    // Drain in order
    readExpect("drain_q0", 32'h11);
    readExpect("drain_q1", 32'h22);
    readExpect("drain_q2", 32'h33);
    readExpect("drain_q3", 32'h44);
    checkOutput("drain_empty", {31'b0, empty4}, 32'd1);
    checkOutput("drain_usedw", {29'b0, usedw4}, 32'd0);
    checkOutput("drain_af",    {31'b0, af4},    32'd0);

    // Full FIFO, simultaneous write and read
    for (int i = 0; i < 4; i++) writeWord(words[i]);
    applyStimulus(1'b1, 1'b1, 32'h55);
    #1;
    checkOutput("wr_rd_full_low", {31'b0, full4}, 32'd0);
    tick();
    checkOutput("wr_rd_usedw", {29'b0, usedw4}, 32'd4);
    checkOutput("wr_rd_head",  q4,              32'h22);
    readExpect("wr_rd_q0", 32'h22);
    readExpect("wr_rd_q1", 32'h33);
    readExpect("wr_rd_q2", 32'h44);
    readExpect("wr_rd_q3", 32'h55);
    checkOutput("wr_rd_empty", {31'b0, empty4}, 32'd1);

    // Full FIFO, write only: dropped
    words[0] = 32'hA1; words[1] = 32'hA2; words[2] = 32'hA3; words[3] = 32'hA4;
    for (int i = 0; i < 4; i++) writeWord(words[i]);
    applyStimulus(1'b1, 1'b0, 32'h66);
    #1;
    checkOutput("drop_full", {31'b0, full4}, 32'd1);
    tick();
    checkOutput("drop_usedw", {29'b0, usedw4}, 32'd4);
    checkOutput("drop_head",  q4,              32'hA1);
`ifdef REGISTER_FIFO_MULTI_ERR_CHECK_EN
    checkOutput("drop_ovf", {31'b0, ovf4}, 32'd1);
`else
    checkOutput("drop_ovf", {31'b0, ovf4}, 32'd0);
`endif
    readExpect("drop_q0", 32'hA1);
    readExpect("drop_q1", 32'hA2);
    readExpect("drop_q2", 32'hA3);
    readExpect("drop_q3", 32'hA4);
    checkOutput("drop_empty", {31'b0, empty4}, 32'd1);
`ifdef REGISTER_FIFO_MULTI_ERR_CHECK_EN
    checkOutput("drop_ovf_sticky", {31'b0, ovf4}, 32'd1);
`endif

    // Empty FIFO, simultaneous write and read: write taken, read ignored
    applyStimulus(1'b1, 1'b1, 32'h77);
    tick();
    checkOutput("empty_wr_rd_usedw", {29'b0, usedw4}, 32'd1);
    checkOutput("empty_wr_rd_empty", {31'b0, empty4}, 32'd0);
    checkOutput("empty_wr_rd_q",     q4,              32'h77);
    readExpect("empty_wr_rd_pop", 32'h77);
    checkOutput("pop_empty", {31'b0, empty4}, 32'd1);

    // Read on empty: ignored
    applyStimulus(1'b0, 1'b1, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("rd_empty_usedw", {29'b0, usedw4}, 32'd0);
    checkOutput("rd_empty_empty", {31'b0, empty4}, 32'd1);
`ifdef REGISTER_FIFO_MULTI_ERR_CHECK_EN
    checkOutput("rd_empty_unf", {31'b0, unf4}, 32'd1);
`else
    checkOutput("rd_empty_unf", {31'b0, unf4}, 32'd0);
`endif

    // Reset clears everything including sticky flags
    writeWord(32'h99);
    applyStimulus(1'b0, 1'b0, 32'h0);
    reset4_n = 1'b0;
    tick();
    reset4_n = 1'b1;
    checkReset4("rst4");

    // Random stream at DEPTH=3 with a mid-stream reset
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (cyc == 500) begin
        wrreq3   = 1'b0;
        rdreq3   = 1'b0;
        reset3_n = 1'b0;
        tick();
        reset3_n = 1'b1;
        sb.delete();
        checkReset3("rst3");
      end
      wr     = 1'($urandom_range(0, 1));
      rd     = 1'($urandom_range(0, 1));
      wrreq3 = wr;
      rdreq3 = rd;
      data3  = 8'($urandom);
      #1;
      sz = sb.size();
      exp_full = (sz == 3) && !rd;
      checkOutput("s_full",  {31'b0, full3},  {31'b0, exp_full});
      checkOutput("s_empty", {31'b0, empty3}, (sz == 0) ? 32'd1 : 32'd0);
      checkOutput("s_usedw", {30'b0, usedw3}, 32'(sz));
      checkOutput("s_af",    {31'b0, af3},    (sz >= 2) ? 32'd1 : 32'd0);
      if (sz != 0) begin
        checkOutput("s_q", {24'b0, q3}, {24'b0, sb[0]});
      end
      tick();
      if (rd && sz != 0) void'(sb.pop_front());
      if (wr && !exp_full) sb.push_back(data3);
    end
    wrreq3 = 1'b0;
    rdreq3 = 1'b0;
    tick();
    checkOutput("s_final_usedw", {30'b0, usedw3}, 32'(sb.size()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
